// File: rtl/uart_echo_buffer_if.sv
// Receiver/transmitter handshake bundle for the echo buffer.
// slave = buffer side, master = uart side driving rx and busy.
interface uart_echo_buffer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic              tx_busy;
  logic [DATA_W-1:0] tx_din;
  logic              tx_start;

  modport master (
    output rx_data,
    output rx_done,
    output tx_busy,
    input  tx_din,
    input  tx_start
  );

  modport slave (
    input  rx_data,
    input  rx_done,
    input  tx_busy,
    output tx_din,
    output tx_start
  );
endinterface

// File: rtl/uart_echo_buffer.sv
// Circular byte FIFO between uart_rx and uart_tx.
// Replays stored bytes to the transmitter one frame at a time.
module uart_echo_buffer #(
  parameter int DATA_W      = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_echo_buffer_if.slave   bus,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic                overflow,
  output logic                ack_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [TW-1:0]         timer;
  logic [TW-1:0]         timer_nx;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  start_nx;
  logic                  ack_set;

  // full/empty use the registered count, so a pop never frees room
  // for a push in the same cycle and a fresh byte is not popped yet
  assign full  = fifo_count == (DEPTH_LOG2 + 1)'(DEPTH);
  assign empty = fifo_count == '0;
  assign push  = bus.rx_done && !full;

  // Next-state, pop request and timeout detection
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    pop      = 1'b0;
    start_nx = 1'b0;
    ack_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          start_nx = 1'b1;
          timer_nx = '0;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_nx = WAIT_DONE;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          ack_set  = 1'b1;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sequencer state, timer, start strobe and sticky ack error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      bus.tx_start <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      bus.tx_start <= start_nx;
      if (ack_set) ack_err <= 1'b1;
    end
  end

  // Storage array is intentionally left unreset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rx_data;
  end

  // Pointers, occupancy, output byte and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      bus.tx_din <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        bus.tx_din <= mem[rd_ptr];
      end
      if (bus.rx_done && full) overflow <= 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_echo_buffer.sv
// Randomized bench for uart_echo_buffer.
// Transaction-level byte queue model plus a simple uart_tx busy model.
module tb_uart_echo_buffer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       ack_err;

  uart_echo_buffer_if #(.DATA_W(8)) bus ();

  uart_echo_buffer #(
    .DATA_W(8),
    .DEPTH_LOG2(4),
    .ACK_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of stored bytes plus sequencer phase
  // expressed with edge timestamps
  logic [7:0] q[$];
  int         seq;
  int         pop_edge;
  int         ncyc;
  bit         start_exp;
  bit         ovf_exp;
  bit         ack_exp;
  logic [7:0] din_exp;

  // Transmitter model: 0 normal, 1 never busy, 2 always busy
  int mode;
  int tx_rise;
  int tx_len;
  int dly_lo, dly_hi, len_lo, len_hi;

  function automatic bit busy_at(input int t);
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return (t >= tx_rise) && (t < tx_rise + tx_len);
  endfunction

  task automatic model_reset();
    q.delete();
    seq       = 0;
    pop_edge  = 0;
    start_exp = 1'b0;
    ovf_exp   = 1'b0;
    ack_exp   = 1'b0;
    din_exp   = 8'h00;
    tx_rise   = -1000;
    tx_len    = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, fifo_count, q.size());
    chk({tag, "_ovf"}, overflow, ovf_exp);
    chk({tag, "_ackerr"}, ack_err, ack_exp);
    chk({tag, "_start"}, bus.tx_start, start_exp);
    chk({tag, "_din"}, bus.tx_din, din_exp);
  endtask

  // One clock: drive at negedge, model at posedge, check at negedge
  task automatic cyc(input bit d, input logic [7:0] v);
    bit b;
    int pre;
    int dly;
    b = busy_at(ncyc + 1);
    bus.rx_done = d;
    bus.rx_data = v;
    bus.tx_busy = b;
    @(posedge clk);
    ncyc++;
    pre = q.size();
    start_exp = 1'b0;
    case (seq)
      0: if (pre > 0) begin
        din_exp   = q.pop_front();
        start_exp = 1'b1;
        seq       = 1;
        pop_edge  = ncyc;
        dly       = $urandom_range(dly_hi, dly_lo);
        tx_rise   = ncyc + 1 + dly;
        tx_len    = $urandom_range(len_hi, len_lo);
      end
      1: if (b) seq = 2;
         else if (ncyc - pop_edge == 64) begin
           ack_exp = 1'b1;
           seq     = 0;
         end
      2: if (!b) seq = 0;
      default: seq = 0;
    endcase
    if (d) begin
      if (pre == 16) ovf_exp = 1'b1;
      else q.push_back(v);
    end
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  // Asynchronous reset applied between clock edges
  task automatic do_reset();
    #2 rst_n = 1'b0;
    bus.rx_done = 1'b0;
    bus.tx_busy = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_tx(input int m, input int dl, input int dh,
                        input int ll, input int lh);
    mode   = m;
    dly_lo = dl;
    dly_hi = dh;
    len_lo = ll;
    len_hi = lh;
  endtask

  int pushed;

  initial begin
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    bus.tx_busy = 1'b0;
    ncyc = 0;
    set_tx(0, 1, 1, 100, 100);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("init");
    rst_n = 1'b1;

    // Reset while a frame is shifting out
    cyc(1'b1, 8'h11);
    cyc(1'b1, 8'h22);
    cyc(1'b1, 8'h33);
    idle(4);
    chk("mid_seq_waitdone", seq, 2);
    do_reset();
    idle(5);

    // Single byte, 100-cycle frame
    cyc(1'b1, 8'hA5);
    idle(110);

    // Burst ordering, 20-cycle frames
    set_tx(0, 1, 1, 20, 20);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i));
    idle(140);

    // Overflow with transmitter stuck busy
    set_tx(2, 1, 1, 3, 3);
    cyc(1'b1, 8'h80);
    idle(3);
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h90 + i));
    idle(2);
    chk("ovf_count", fifo_count, 16);
    chk("ovf_flag", overflow, 1);
    set_tx(0, 0, 2, 1, 3);
    idle(160);
    do_reset();

    // Random stream across pointer wrap with coincident push/pop
    set_tx(0, 0, 2, 1, 3);
    pushed = 0;
    while (pushed < 40) begin
      if ($urandom_range(3, 0) == 0) begin
        cyc(1'b1, 8'($urandom));
        pushed++;
      end else begin
        cyc(1'b0, 8'($urandom));
      end
    end
    idle(200);
    chk("wrap_drain", fifo_count, 0);
    do_reset();

    // Acknowledge timeout, busy never rises
    set_tx(1, 1, 1, 1, 1);
    cyc(1'b1, 8'h3C);
    cyc(1'b1, 8'h3D);
    idle(160);
    chk("to_ackerr", ack_err, 1);
    chk("to_count", fifo_count, 0);
    chk("to_last", bus.tx_din, 8'h3D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
